// File: rtl/scan_addr_seq.sv
// Address sequencer feeding the 4-to-16 decoder.
// Sweeps a captured address window, holding each address for dwell+1 cycles.
module scan_addr_seq #(
    parameter int ADDR_W  = 4,
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [ADDR_W-1:0]  first_q, first_nxt;
    logic [ADDR_W-1:0]  last_q, last_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               cont_q, cont_nxt;
    logic               done_nxt, wrap_nxt;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        first_nxt = first_q;
        last_nxt  = last_q;
        dwell_nxt = dwell_q;
        cont_nxt  = cont_q;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        wrap_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    first_nxt = first_addr;
                    last_nxt  = last_addr;
                    dwell_nxt = dwell;
                    cont_nxt  = continuous;
                    addr_nxt  = first_addr;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                // stop wins over any step or end-of-sweep at the same edge
                if (stop) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == dwell_q) begin
                    cnt_nxt = '0;
                    if (addr == last_q) begin
                        if (cont_q) begin
                            addr_nxt = first_q;
                            wrap_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
            first_q    <= '0;
            last_q     <= '0;
            dwell_q    <= '0;
            cont_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            addr_valid <= (state_nxt == RUN);
            busy       <= (state_nxt == RUN);
            done       <= done_nxt;
            wrap       <= wrap_nxt;
            first_q    <= first_nxt;
            last_q     <= last_nxt;
            dwell_q    <= dwell_nxt;
            cont_q     <= cont_nxt;
            cnt        <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_scan_addr_seq.sv
// Scoreboard bench for scan_addr_seq: a window-level reference model predicts
// every output cycle, and an independent monitor compares the DUT against it.
module tb_scan_addr_seq;

    typedef struct packed {
        logic [3:0] addr;
        logic       valid;
        logic       busy;
        logic       done;
        logic       wrap;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] first_addr = '0;
    logic [3:0] last_addr = '0;
    logic [7:0] dwell = '0;
    logic [3:0] addr;
    logic       addr_valid, busy, done, wrap;

    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 1'b0;

    rec_t exp_q[$];
    rec_t plan[$];
    rec_t cur = '0;

    logic [3:0] m_first, m_last;
    logic [7:0] m_dwell;
    logic       m_cont;

    always #5 clk = ~clk;

    scan_addr_seq #(.ADDR_W(4), .DWELL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .dwell      (dwell),
        .addr       (addr),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    // One full pass over the captured window, each address repeated dwell+1 times.
    task automatic fill_scan(input bit wrap_first);
        int   len;
        rec_t r;
        len = ((int'(m_last) - int'(m_first) + 16) % 16) + 1;
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j <= int'(m_dwell); j++) begin
                r       = '0;
                r.addr  = 4'((int'(m_first) + i) % 16);
                r.valid = 1'b1;
                r.busy  = 1'b1;
                r.wrap  = wrap_first && (i == 0) && (j == 0);
                plan.push_back(r);
            end
        end
    endtask

    // Predicts the outputs visible after the coming rising edge.
    task automatic model_step();
        rec_t r;
        if (rst) begin
            plan.delete();
            cur = '0;
        end else if (cur.busy) begin
            if (stop) begin
                plan.delete();
                r      = '0;
                r.addr = cur.addr;
                cur    = r;
            end else begin
                if (plan.size() == 0) fill_scan(1'b1);
                cur = plan.pop_front();
            end
        end else if (start && !stop) begin
            m_first = first_addr;
            m_last  = last_addr;
            m_dwell = dwell;
            m_cont  = continuous;
            plan.delete();
            fill_scan(1'b0);
            if (!m_cont) begin
                r      = '0;
                r.addr = m_last;
                r.done = 1'b1;
                plan.push_back(r);
            end
            cur = plan.pop_front();
        end else begin
            r      = '0;
            r.addr = cur.addr;
            cur    = r;
        end
        exp_q.push_back(cur);
    endtask

    task automatic cyc(input logic r, input logic s, input logic p, input logic c,
                       input logic [3:0] f, input logic [3:0] l, input logic [7:0] d);
        @(negedge clk);
        rst        = r;
        start      = s;
        stop       = p;
        continuous = c;
        first_addr = f;
        last_addr  = l;
        dwell      = d;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, continuous, first_addr, last_addr, dwell);
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        rec_t e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e       = exp_q.pop_front();
                a.addr  = addr;
                a.valid = addr_valid;
                a.busy  = busy;
                a.done  = done;
                a.wrap  = wrap;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL out_vec t=%0t got addr=%0d v=%b b=%b d=%b w=%b expected addr=%0d v=%b b=%b d=%b w=%b",
                             $time, a.addr, a.valid, a.busy, a.done, a.wrap,
                             e.addr, e.valid, e.busy, e.done, e.wrap);
                end
            end
        end
    end

    initial begin
        // Reset held two cycles with start high
        cyc(1, 1, 0, 0, 4'd3, 4'd4, 8'd0);
        cyc(1, 1, 0, 0, 4'd3, 4'd4, 8'd0);
        cyc(0, 0, 0, 0, 4'd3, 4'd4, 8'd0);

        // Basic sweep 2..5
        cyc(0, 1, 0, 0, 4'd2, 4'd5, 8'd0);
        idle(7);

        // Window through the wrap point, dwell 2
        cyc(0, 1, 0, 0, 4'd14, 4'd1, 8'd2);
        cyc(0, 0, 0, 1, 4'd5, 4'd6, 8'd7);
        idle(14);

        // Continuous full range, three scans, then stop
        cyc(0, 1, 0, 1, 4'd0, 4'd15, 8'd0);
        idle(50);
        cyc(0, 0, 1, 0, 4'd0, 4'd15, 8'd0);
        idle(2);

        // Abort while addr=6 in a continuous 3..9 scan
        cyc(0, 1, 0, 1, 4'd3, 4'd9, 8'd1);
        idle(6);
        cyc(0, 0, 1, 1, 4'd3, 4'd9, 8'd1);
        idle(2);
        cyc(0, 1, 1, 0, 4'd1, 4'd2, 8'd0);
        idle(2);

        // Single-address window
        cyc(0, 1, 0, 0, 4'd7, 4'd7, 8'd0);
        idle(3);

        // Start held high through done: back-to-back sweeps
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 4'd1, 4'd2, 8'd0);
        idle(3);

        // Reset mid-sweep
        cyc(0, 1, 0, 0, 4'd4, 4'd12, 8'd1);
        idle(4);
        cyc(1, 0, 0, 0, 4'd4, 4'd12, 8'd1);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) < 1),
                ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 3),
                1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)),
                8'($urandom_range(0, 3)));
        end
        idle(4);

        stim_done = 1'b1;
        @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout stim_done=%0d expected 1", stim_done);
        $fatal(1, "timeout");
    end

endmodule
